mips_control_fsm: RTL

Multicycle control unit for the MIPS-I CPU core: owns the instruction-phase state register and drives every datapath control line (ALU source/operation, PC update, memory strobes, register write-back) for each phase. It generalises the combinational phase decoder: it sequences phases itself, stalls on a variable-latency memory bus and on the multiply/divide unit, and generates byte enables for sub-word loads and stores. It sits between the instruction register / ALU flags and the datapath muxes.

---
 rtl/mips_pkg.sv | 137 +++++++++++++
 rtl/byteenable_gen.sv | 29 ++
 rtl/mips_control_fsm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-I definitions: phase encoding, ALU operations, opcode/function
// constants, load-extension codes and the instruction-field decoder.
package mips_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned LDEXT_W  = 3;
  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned MD_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    FETCH       = 3'd0,
    DECODE      = 3'd1,
    EXECUTE     = 3'd2,
    MEM_ACCESS  = 3'd3,
    WRITE_BACK  = 3'd4,
    MULDIV_WAIT = 3'd5,
    HALT        = 3'd6
  } state_t;

  typedef enum logic [ALUCTL_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9,
    ALU_NOR = 4'd12
  } ALUOperation_t;

  typedef enum logic [1:0] {SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2} mem_size_t;

  // Lane is taken from byteenable; this code only carries width and extension.
  typedef enum logic [LDEXT_W-1:0] {
    LX_WORD   = 3'd0,
    LX_BYTE_U = 3'd1,
    LX_BYTE_S = 3'd2,
    LX_HALF_U = 3'd3,
    LX_HALF_S = 3'd4
  } load_ext_t;

  typedef enum logic [2:0] {
    IC_NOP, IC_ALU_R, IC_ALU_I, IC_BRANCH, IC_JUMP, IC_MULDIV, IC_LOAD, IC_STORE
  } inst_class_t;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [FIELD_W-1:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [FIELD_W-1:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [FIELD_W-1:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [FIELD_W-1:0] OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH    = 6'h21;
  localparam logic [FIELD_W-1:0] OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU   = 6'h25;
  localparam logic [FIELD_W-1:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

  localparam logic [FIELD_W-1:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03;
  localparam logic [FIELD_W-1:0] FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_MULT = 6'h18;
  localparam logic [FIELD_W-1:0] FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [FIELD_W-1:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22;
  localparam logic [FIELD_W-1:0] FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25;
  localparam logic [FIELD_W-1:0] FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT  = 6'h2A;
  localparam logic [FIELD_W-1:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    inst_class_t   cls;
    ALUOperation_t alu_op;
    logic          unsign;
    logic          link;
    logic          jreg;
    logic          bne;
    mem_size_t     size;
  } decode_t;

  function automatic decode_t decode_inst(input logic [FIELD_W-1:0] opcode,
                                          input logic [FIELD_W-1:0] func_code,
                                          input logic               byte_ls);
    decode_t d;
    d.cls    = IC_NOP;
    d.alu_op = ALU_ADD;
    d.unsign = 1'b0;
    d.link   = 1'b0;
    d.jreg   = 1'b0;
    d.bne    = 1'b0;
    d.size   = SZ_WORD;
    case (opcode)
      OP_RTYPE: begin
        d.cls = IC_ALU_R;
        case (func_code)
          FN_SLL:   d.alu_op = ALU_SLL;
          FN_SRL:   d.alu_op = ALU_SRL;
          FN_SRA:   d.alu_op = ALU_SRA;
          FN_ADD:   d.alu_op = ALU_ADD;
          FN_ADDU:  begin d.alu_op = ALU_ADD; d.unsign = 1'b1; end
          FN_SUB:   d.alu_op = ALU_SUB;
          FN_SUBU:  begin d.alu_op = ALU_SUB; d.unsign = 1'b1; end
          FN_AND:   d.alu_op = ALU_AND;
          FN_OR:    d.alu_op = ALU_OR;
          FN_XOR:   d.alu_op = ALU_XOR;
          FN_NOR:   d.alu_op = ALU_NOR;
          FN_SLT:   d.alu_op = ALU_SLT;
          FN_SLTU:  begin d.alu_op = ALU_SLT; d.unsign = 1'b1; end
          FN_JR:    begin d.cls = IC_JUMP; d.jreg = 1'b1; end
          FN_JALR:  begin d.cls = IC_JUMP; d.jreg = 1'b1; d.link = 1'b1; end
          FN_MULT, FN_DIV:   d.cls = IC_MULDIV;
          FN_MULTU, FN_DIVU: begin d.cls = IC_MULDIV; d.unsign = 1'b1; end
          default:  d.cls = IC_NOP;
        endcase
      end
      OP_J:     d.cls = IC_JUMP;
      OP_JAL:   begin d.cls = IC_JUMP; d.link = 1'b1; end
      OP_BEQ:   begin d.cls = IC_BRANCH; d.alu_op = ALU_SUB; end
      OP_BNE:   begin d.cls = IC_BRANCH; d.alu_op = ALU_SUB; d.bne = 1'b1; end
      OP_ADDI:  d.cls = IC_ALU_I;
      OP_ADDIU: begin d.cls = IC_ALU_I; d.unsign = 1'b1; end
      OP_SLTI:  begin d.cls = IC_ALU_I; d.alu_op = ALU_SLT; end
      OP_SLTIU: begin d.cls = IC_ALU_I; d.alu_op = ALU_SLT; d.unsign = 1'b1; end
      // Logical immediates are zero-extended; unsign tells the datapath so.
      OP_ANDI:  begin d.cls = IC_ALU_I; d.alu_op = ALU_AND; d.unsign = 1'b1; end
      OP_ORI:   begin d.cls = IC_ALU_I; d.alu_op = ALU_OR;  d.unsign = 1'b1; end
      OP_XORI:  begin d.cls = IC_ALU_I; d.alu_op = ALU_XOR; d.unsign = 1'b1; end
      OP_LUI:   begin d.cls = IC_ALU_I; d.alu_op = ALU_LUI; end
      OP_LW:    d.cls = IC_LOAD;
      OP_SW:    d.cls = IC_STORE;
      OP_LB:    if (byte_ls) begin d.cls = IC_LOAD;  d.size = SZ_BYTE; end
      OP_LBU:   if (byte_ls) begin d.cls = IC_LOAD;  d.size = SZ_BYTE; d.unsign = 1'b1; end
      OP_LH:    if (byte_ls) begin d.cls = IC_LOAD;  d.size = SZ_HALF; end
      OP_LHU:   if (byte_ls) begin d.cls = IC_LOAD;  d.size = SZ_HALF; d.unsign = 1'b1; end
      OP_SB:    if (byte_ls) begin d.cls = IC_STORE; d.size = SZ_BYTE; end
      OP_SH:    if (byte_ls) begin d.cls = IC_STORE; d.size = SZ_HALF; end
      default:  d.cls = IC_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/byteenable_gen.sv
// Byte-lane enables and load-extension code for word, half and byte accesses.
module byteenable_gen
  import mips_pkg::*;
(
  input  logic [1:0] size,
  input  logic       unsign,
  input  logic [1:0] offset,
  output logic [3:0] byteenable,
  output logic [2:0] load_ext
);

  // Misaligned halves fall back to the enclosing aligned half.
  always_comb begin
    byteenable = 4'b1111;
    load_ext   = LX_WORD;
    case (size)
      SZ_HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        load_ext   = unsign ? LX_HALF_U : LX_HALF_S;
      end
      SZ_BYTE: begin
        byteenable = 4'b0001 << offset;
        load_ext   = unsign ? LX_BYTE_U : LX_BYTE_S;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS-I control unit: sequences instruction phases, stalls on memory
// and mult/div, and drives every datapath control line as a decode of the phase.
module mips_control_fsm
  import mips_pkg::*;
#(
  parameter bit          BYTE_LS       = 1'b1,
  parameter bit          MULDIV_FIXED  = 1'b0,
  parameter int unsigned MULDIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func_code,
  input  logic       alu_zero,
  input  logic [1:0] addr_low,
  input  logic       pc_zero,
  input  logic       mem_waitrequest,
  input  logic       muldiv_busy,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       unsign,
  output logic       muldiv_start,
  output logic       link,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUctl,
  output logic [3:0] byteenable,
  output logic [2:0] load_ext,
  output logic [2:0] state,
  output logic       active
);

  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MULDIV_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  last_jump_q;
  logic [MD_CNT_W-1:0]   md_cnt_q;
  decode_t               dec;
  logic [3:0]            be_w;
  logic [2:0]            lx_w;
  logic                  md_done;

  assign dec     = decode_inst(opcode, func_code, BYTE_LS);
  assign md_done = MULDIV_FIXED ? (md_cnt_q == MD_LAST) : !muldiv_busy;
  assign state   = state_q;
  assign active  = reset || (state_q != HALT);

  byteenable_gen u_be (
    .size       (dec.size),
    .unsign     (dec.unsign),
    .offset     (addr_low),
    .byteenable (be_w),
    .load_ext   (lx_w)
  );

  // Phase register, jump-history flag and saturating mult/div wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      last_jump_q <= 1'b0;
      md_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXECUTE) last_jump_q <= (dec.cls == IC_JUMP);
      if (state_q != MULDIV_WAIT)  md_cnt_q <= '0;
      else if (md_cnt_q != '1)     md_cnt_q <= md_cnt_q + MD_CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    unsign       = 1'b0;
    muldiv_start = 1'b0;
    link         = 1'b0;
    ALUSrcB      = 2'b00;
    PCSource     = 2'b00;
    ALUctl       = ALU_ADD;
    byteenable   = 4'b0000;
    load_ext     = LX_WORD;

    case (state_q)
      FETCH: begin
        MemRead    = 1'b1;
        byteenable = 4'b1111;
        ALUSrcB    = 2'b01;
        IRWrite    = !mem_waitrequest;
        PCWrite    = !mem_waitrequest;
        if (!mem_waitrequest) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        state_d = (pc_zero && last_jump_q) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        state_d = FETCH;
        case (dec.cls)
          IC_ALU_R, IC_ALU_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = (dec.cls == IC_ALU_I) ? 2'b10 : 2'b00;
            ALUctl  = dec.alu_op;
            unsign  = dec.unsign;
            state_d = WRITE_BACK;
          end
          IC_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUctl      = ALU_SUB;
            PCSource    = 2'b01;
            PCWriteCond = dec.bne ^ alu_zero;
          end
          IC_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = dec.jreg ? 2'b11 : 2'b10;
            link     = dec.link;
            if (dec.link) state_d = WRITE_BACK;
          end
          IC_MULDIV: begin
            muldiv_start = 1'b1;
            unsign       = dec.unsign;
            state_d      = MULDIV_WAIT;
          end
          IC_LOAD, IC_STORE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = MEM_ACCESS;
          end
          default: ;
        endcase
      end
      MEM_ACCESS: begin
        IorD       = 1'b1;
        MemRead    = (dec.cls == IC_LOAD);
        MemWrite   = (dec.cls == IC_STORE);
        byteenable = be_w;
        load_ext   = lx_w;
        if (!mem_waitrequest) state_d = (dec.cls == IC_LOAD) ? WRITE_BACK : FETCH;
      end
      WRITE_BACK: begin
        RegWrite = 1'b1;
        RegDst   = (dec.cls == IC_ALU_R) || (dec.jreg && dec.link);
        MemtoReg = (dec.cls == IC_LOAD);
        if (dec.cls == IC_LOAD) load_ext = lx_w;
        state_d  = FETCH;
      end
      MULDIV_WAIT: if (md_done) state_d = FETCH;
      HALT:        state_d = HALT;
      default:     state_d = FETCH;
    endcase

    // Nothing may strobe while reset is held, whatever phase was interrupted.
    if (reset) begin
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      muldiv_start = 1'b0;
      link         = 1'b0;
      byteenable   = 4'b0000;
    end
  end

endmodule
